vga_timing_monitor: RTL

- Receive-side counterpart of the VGA output path, in the same clk_25_175 domain.
- Consumes the h_sync/v_sync/RGB stream produced by the VGA core and recovers pixel coordinates, then checks sync widths, line length and frame height against nominal 640x480@60 timing.
- Produces a per-frame pixel signature for board self-test and regression checks of the renderer.

---
 rtl/vga_timing_pkg.sv | 14 +
 rtl/vga_sync_edge.sv | 24 ++
 rtl/vga_timing_monitor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: nominal 640x480@60 timing shared with the VGA core, plus the lock states
package vga_timing_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int H_TOTAL = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int V_TOTAL = 525;
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam int LOCK_FRAMES = 2;
  typedef enum logic [0:0] {HUNT = 1'b0, LOCKED = 1'b1} lock_state_t;
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers one sync input and flags its assertion and deassertion edges
//   clk_25_175, reset (async, active-low), sync in; assert_ev / deassert_ev out (decoded from the registered copy)
module vga_sync_edge #(
  parameter logic ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
  input  logic clk_25_175,
  input  logic reset,
  input  logic sync,
  output logic assert_ev,
  output logic deassert_ev
);
  logic sync_q, sync_p;
  // Both stages reset to the asserted level so a sync already active at release is not taken as a new edge.
  always_ff @(posedge clk_25_175 or negedge reset)
    if (!reset) begin
      sync_q <= ACTIVE;
      sync_p <= ACTIVE;
    end else begin
      sync_q <= sync;
      sync_p <= sync_q;
    end
  assign assert_ev = sync_q == ACTIVE && sync_p != ACTIVE;
  assign deassert_ev = sync_q != ACTIVE && sync_p == ACTIVE;
endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers pixel coordinates from a VGA sync/RGB stream and checks its timing
//   in : clk_25_175, reset (async, active-low), h_sync, v_sync, r/g/b, clear_err
//   out: pix_x/pix_y/pix_data/pix_valid, frame_start, locked, err_hsw/err_hlen/err_vlen (sticky),
//        frame_sum/frame_sum_valid (per-frame signature), frame_count
module vga_timing_monitor #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BACK = vga_timing_pkg::H_BACK,
  parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BACK = vga_timing_pkg::V_BACK,
  parameter int V_TOTAL = vga_timing_pkg::V_TOTAL,
  parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic        clk_25_175,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic        clear_err,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        err_hsw,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic [15:0] frame_sum,
  output logic        frame_sum_valid,
  output logic [15:0] frame_count
);
  import vga_timing_pkg::*;
  localparam logic [9:0] H_OFF = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0] V_OFF = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [9:0] H_SW = 10'(H_SYNC);
  localparam logic [10:0] H_LEN = 11'(H_TOTAL);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [1:0] LOCK_N = 2'(LOCK_FRAMES);
  logic [11:0] rgb_q;
  logic clr_q, he, hd, ve, vd_unused;
  logic [9:0] hcnt, lcnt, cur_h, cur_l;
  logic h_seen, v_seen, dirty, vis, hsw_ev, hlen_ev, vlen_ev, err_ev, clean;
  lock_state_t state, state_n;
  logic [1:0] good, good_n;
  logic [15:0] sum;
  vga_sync_edge #(.ACTIVE(SYNC_ACTIVE)) u_hsync (
    .clk_25_175(clk_25_175), .reset(reset), .sync(h_sync), .assert_ev(he), .deassert_ev(hd)
  );
  vga_sync_edge #(.ACTIVE(SYNC_ACTIVE)) u_vsync (
    .clk_25_175(clk_25_175), .reset(reset), .sync(v_sync), .assert_ev(ve), .deassert_ev(vd_unused)
  );
  always_ff @(posedge clk_25_175 or negedge reset)
    if (!reset) begin
      rgb_q <= '0;
      clr_q <= 1'b0;
    end else begin
      rgb_q <= {r, g, b};
      clr_q <= clear_err;
    end
  // cur_h/cur_l are the coordinates of the sample currently in the input register.
  always_comb begin
    cur_h = he ? 10'd0 : (&hcnt ? hcnt : hcnt + 10'd1);
    cur_l = ve ? 10'd0 : (he && !(&lcnt) ? lcnt + 10'd1 : lcnt);
    hsw_ev = hd && h_seen && cur_h != H_SW;
    hlen_ev = he && h_seen && {1'b0, hcnt} + 11'd1 != H_LEN;
    vlen_ev = ve && v_seen && lcnt != V_LAST;
    err_ev = hsw_ev || hlen_ev || vlen_ev;
    clean = !(dirty || err_ev);
    vis = cur_h >= H_OFF && cur_h <= H_END && cur_l >= V_OFF && cur_l <= V_END;
    good_n = state == LOCKED ? (err_ev ? 2'd0 : good) : (ve && v_seen ? (clean ? good + 2'd1 : 2'd0) : good);
    state_n = state == LOCKED ? (err_ev ? HUNT : LOCKED) : (good_n == LOCK_N ? LOCKED : HUNT);
  end
  always_ff @(posedge clk_25_175 or negedge reset)
    if (!reset) begin
      hcnt <= '0;
      lcnt <= '0;
      h_seen <= 1'b0;
      v_seen <= 1'b0;
      dirty <= 1'b0;
      state <= HUNT;
      good <= '0;
      sum <= '0;
      err_hsw <= 1'b0;
      err_hlen <= 1'b0;
      err_vlen <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_valid <= 1'b0;
      pix_data <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
      frame_sum <= '0;
      frame_sum_valid <= 1'b0;
    end else begin
      hcnt <= cur_h;
      lcnt <= cur_l;
      h_seen <= h_seen || he;
      v_seen <= v_seen || ve;
      dirty <= !ve && (dirty || err_ev);
      state <= state_n;
      good <= good_n;
      // A pixel landing on the frame boundary seeds the new frame's signature.
      sum <= vis ? ((ve ? 16'd0 : {sum[14:0], sum[15]}) ^ {4'd0, rgb_q}) : (ve ? 16'd0 : sum);
      err_hsw <= hsw_ev || (err_hsw && !clr_q);
      err_hlen <= hlen_ev || (err_hlen && !clr_q);
      err_vlen <= vlen_ev || (err_vlen && !clr_q);
      if (vis) begin
        pix_x <= cur_h - H_OFF;
        pix_y <= cur_l - V_OFF;
      end
      pix_valid <= vis && state_n == LOCKED;
      pix_data <= rgb_q;
      frame_start <= ve;
      frame_count <= frame_count + {15'd0, ve};
      if (ve) frame_sum <= sum;
      frame_sum_valid <= ve && state == LOCKED && clean;
    end
  assign locked = state == LOCKED;
endmodule
